// File: rtl/lsu.sv
// Load/store stage: issues one data-memory request per memory op, aligns
// and extends load data, and registers every result toward writeback.
module lsu #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ex_valid,
    output logic          o_ex_ready,
    input  logic [AW-1:0] i_mem_addr,
    input  logic [DW-1:0] i_mem_wdata,
    input  logic [10:0]   i_ls_info,
    input  logic          i_mem_read,
    input  logic          i_mem_write,
    input  logic          i_rd_wen,
    input  logic [4:0]    i_rd_addr,
    input  logic [DW-1:0] i_rd_data,
    output logic          o_dmem_req,
    output logic          o_dmem_we,
    output logic [AW-1:0] o_dmem_addr,
    output logic [DW-1:0] o_dmem_wdata,
    output logic [7:0]    o_dmem_wstrb,
    input  logic          i_dmem_gnt,
    input  logic          i_dmem_rvalid,
    input  logic [DW-1:0] i_dmem_rdata,
    output logic          o_wb_valid,
    output logic          o_wb_rd_wen,
    output logic [4:0]    o_wb_rd_addr,
    output logic [DW-1:0] o_wb_rd_data,
    output logic          o_misalign,
    output logic [AW-1:0] o_bad_addr,
    output logic [DW-1:0] o_fwd_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;

    logic [2:0] off_q;
    logic [1:0] size_q;
    logic       sgn_q;
    logic       load_q;
    logic       rd_wen_q;
    logic [4:0] rd_addr_q;

    logic          is_load;
    logic          is_store;
    logic          is_mem;
    logic [1:0]    size_d;
    logic          sgn_d;
    logic          misal;
    logic [7:0]    strb_base;
    logic [7:0]    strb_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] rshift;
    logic [DW-1:0] ldata;

    assign o_ex_ready    = (state == IDLE);
    assign o_fwd_rd_data = i_rd_data;

    // Read wins when both flags are set; a missing width bit means doubleword.
    always_comb begin
        is_load  = i_mem_read;
        is_store = i_mem_write & ~i_mem_read;
        is_mem   = is_load | is_store;
        size_d   = 2'd3;
        sgn_d    = 1'b0;
        if (is_load) begin
            unique case (1'b1)
                i_ls_info[10]: begin size_d = 2'd0; sgn_d = 1'b1; end
                i_ls_info[9]:  begin size_d = 2'd1; sgn_d = 1'b1; end
                i_ls_info[8]:  begin size_d = 2'd2; sgn_d = 1'b1; end
                i_ls_info[7]:  size_d = 2'd3;
                i_ls_info[6]:  size_d = 2'd0;
                i_ls_info[5]:  size_d = 2'd1;
                i_ls_info[4]:  size_d = 2'd2;
                default:       size_d = 2'd3;
            endcase
        end else if (is_store) begin
            unique case (1'b1)
                i_ls_info[3]: size_d = 2'd0;
                i_ls_info[2]: size_d = 2'd1;
                i_ls_info[1]: size_d = 2'd2;
                i_ls_info[0]: size_d = 2'd3;
                default:      size_d = 2'd3;
            endcase
        end
    end

    always_comb begin
        unique case (size_d)
            2'd0: begin misal = 1'b0;               strb_base = 8'h01; end
            2'd1: begin misal = i_mem_addr[0];      strb_base = 8'h03; end
            2'd2: begin misal = |i_mem_addr[1:0];   strb_base = 8'h0F; end
            default: begin misal = |i_mem_addr[2:0]; strb_base = 8'hFF; end
        endcase
        strb_d  = strb_base << i_mem_addr[2:0];
        wdata_d = i_mem_wdata << {i_mem_addr[2:0], 3'b000};
    end

    always_comb begin
        rshift = i_dmem_rdata >> {off_q, 3'b000};
        unique case (size_q)
            2'd0: ldata = {{56{sgn_q & rshift[7]}}, rshift[7:0]};
            2'd1: ldata = {{48{sgn_q & rshift[15]}}, rshift[15:0]};
            2'd2: ldata = {{32{sgn_q & rshift[31]}}, rshift[31:0]};
            default: ldata = rshift;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            off_q        <= '0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            load_q       <= 1'b0;
            rd_wen_q     <= 1'b0;
            rd_addr_q    <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_wstrb <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_rd_wen  <= 1'b0;
            o_wb_rd_addr <= '0;
            o_wb_rd_data <= '0;
            o_misalign   <= 1'b0;
            o_bad_addr   <= '0;
        end else begin
            o_wb_valid <= 1'b0;
            o_misalign <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_ex_valid) begin
                        if (!is_mem) begin
                            o_wb_valid   <= 1'b1;
                            o_wb_rd_wen  <= i_rd_wen;
                            o_wb_rd_addr <= i_rd_addr;
                            o_wb_rd_data <= i_rd_data;
                        end else if (misal) begin
                            o_wb_valid   <= 1'b1;
                            o_misalign   <= 1'b1;
                            o_wb_rd_wen  <= 1'b0;
                            o_wb_rd_addr <= i_rd_addr;
                            o_wb_rd_data <= '0;
                            o_bad_addr   <= i_mem_addr;
                        end else begin
                            off_q        <= i_mem_addr[2:0];
                            size_q       <= size_d;
                            sgn_q        <= sgn_d;
                            load_q       <= is_load;
                            rd_wen_q     <= i_rd_wen;
                            rd_addr_q    <= i_rd_addr;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= is_store;
                            o_dmem_addr  <= {i_mem_addr[AW-1:3], 3'b000};
                            o_dmem_wdata <= wdata_d;
                            o_dmem_wstrb <= strb_d;
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_gnt) begin
                        o_dmem_req <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        o_wb_valid   <= 1'b1;
                        o_wb_rd_wen  <= load_q & rd_wen_q;
                        o_wb_rd_addr <= rd_addr_q;
                        o_wb_rd_data <= load_q ? ldata : '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, randomized ops against a
// byte-level reference model, and hand-written stall/reset sequences.
module tb_lsu;

    localparam logic [10:0] LB  = 11'h400;
    localparam logic [10:0] LH  = 11'h200;
    localparam logic [10:0] LW  = 11'h100;
    localparam logic [10:0] LD  = 11'h080;
    localparam logic [10:0] LBU = 11'h040;
    localparam logic [10:0] LHU = 11'h020;
    localparam logic [10:0] LWU = 11'h010;
    localparam logic [10:0] SB  = 11'h008;
    localparam logic [10:0] SH  = 11'h004;
    localparam logic [10:0] SW  = 11'h002;
    localparam logic [10:0] SD  = 11'h001;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ex_valid;
    logic        o_ex_ready;
    logic [63:0] i_mem_addr;
    logic [63:0] i_mem_wdata;
    logic [10:0] i_ls_info;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic [63:0] i_rd_data;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [63:0] o_dmem_addr;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_wstrb;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [63:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic        o_wb_rd_wen;
    logic [4:0]  o_wb_rd_addr;
    logic [63:0] o_wb_rd_data;
    logic        o_misalign;
    logic [63:0] o_bad_addr;
    logic [63:0] o_fwd_rd_data;

    lsu dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_ls_info(i_ls_info), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_rd_wen(i_rd_wen),
        .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_gnt(i_dmem_gnt),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_rd_wen(o_wb_rd_wen),
        .o_wb_rd_addr(o_wb_rd_addr), .o_wb_rd_data(o_wb_rd_data),
        .o_misalign(o_misalign), .o_bad_addr(o_bad_addr),
        .o_fwd_rd_data(o_fwd_rd_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [10:0] info;
        logic        rd;
        logic        wr;
        logic        rwen;
        logic [4:0]  rda;
        logic [63:0] rdd;
        logic [63:0] rdata;
        int          gd;
        int          rvd;
        logic        junk;
    } op_t;

    typedef struct {
        op_t         o;
        int          e_lat;
        logic        e_mis;
        logic        e_wen;
        logic        chk_data;
        logic [63:0] e_data;
        logic        e_req;
        logic [63:0] e_daddr;
        logic        e_we;
        logic [7:0]  e_wstrb;
        logic [63:0] e_dwdata;
    } vec_t;

    typedef struct {
        logic        ok;
        int          lat;
        logic        wen;
        logic        mis;
        logic [4:0]  rda;
        logic [63:0] data;
        logic [63:0] bad;
        logic        req_seen;
        logic [63:0] daddr;
        logic        we;
        logic [7:0]  wstrb;
        logic [63:0] dwdata;
        logic        stable;
        logic        wb_after;
        logic        rdy_after;
    } res_t;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    endtask

    function automatic op_t mk(logic [63:0] addr, logic [63:0] wdata,
                               logic [10:0] info, logic rd, logic wr,
                               logic rwen, logic [4:0] rda,
                               logic [63:0] rdd, logic [63:0] rdata,
                               int gd, int rvd, logic junk);
        op_t o;
        o.addr = addr; o.wdata = wdata; o.info = info;
        o.rd = rd; o.wr = wr; o.rwen = rwen; o.rda = rda;
        o.rdd = rdd; o.rdata = rdata; o.gd = gd; o.rvd = rvd;
        o.junk = junk;
        return o;
    endfunction

    function automatic vec_t tv(op_t o, int lat, logic mis, logic wen,
                                logic chkd, logic [63:0] data, logic req,
                                logic [63:0] daddr, logic we,
                                logic [7:0] wstrb, logic [63:0] dwdata);
        vec_t v;
        v.o = o; v.e_lat = lat; v.e_mis = mis; v.e_wen = wen;
        v.chk_data = chkd; v.e_data = data; v.e_req = req;
        v.e_daddr = daddr; v.e_we = we; v.e_wstrb = wstrb;
        v.e_dwdata = dwdata;
        return v;
    endfunction

    // Reference: access size in bytes, byte offset, plain shifts and masks.
    function automatic vec_t model(op_t o);
        vec_t v;
        int sz;
        logic sgn, ld, st;
        int off;
        logic [63:0] m, val;
        ld = o.rd;
        st = o.wr && !o.rd;
        sz = 8;
        sgn = 1'b0;
        if (ld) begin
            if (o.info[10]) begin sz = 1; sgn = 1'b1; end
            else if (o.info[9]) begin sz = 2; sgn = 1'b1; end
            else if (o.info[8]) begin sz = 4; sgn = 1'b1; end
            else if (o.info[6]) sz = 1;
            else if (o.info[5]) sz = 2;
            else if (o.info[4]) sz = 4;
        end else if (st) begin
            if (o.info[3]) sz = 1;
            else if (o.info[2]) sz = 2;
            else if (o.info[1]) sz = 4;
        end
        off = int'(o.addr[2:0]);
        v.o = o;
        v.e_mis = (ld || st) && ((int'(o.addr[5:0]) % sz) != 0);
        v.e_req = (ld || st) && !v.e_mis;
        v.e_lat = v.e_req ? 3 + o.gd + o.rvd : 1;
        v.e_we = st;
        v.e_daddr = o.addr - 64'(off);
        v.e_wstrb = 8'(((1 << sz) - 1) << off);
        v.e_dwdata = o.wdata << (8 * off);
        m = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF
                      : ((64'd1 << (8 * sz)) - 64'd1);
        val = (o.rdata >> (8 * off)) & m;
        if (sgn && val[8 * sz - 1]) val = val | ~m;
        v.e_wen = 1'b0;
        v.chk_data = 1'b0;
        v.e_data = '0;
        if (!(ld || st)) begin
            v.e_wen = o.rwen; v.e_data = o.rdd; v.chk_data = 1'b1;
        end else if (!v.e_mis && ld) begin
            v.e_wen = o.rwen; v.e_data = val; v.chk_data = 1'b1;
        end
        return v;
    endfunction

    // Drives one op from a negedge and plays the memory side; ends on a negedge.
    task automatic do_op(input op_t o, output res_t r);
        int nreq, nw;
        logic granted;
        nreq = 0; nw = 0; granted = 1'b0;
        r.ok = 0; r.lat = 0; r.wen = 0; r.mis = 0; r.rda = 0;
        r.data = 0; r.bad = 0; r.req_seen = 0; r.daddr = 0; r.we = 0;
        r.wstrb = 0; r.dwdata = 0; r.stable = 1; r.wb_after = 1;
        r.rdy_after = 0;
        i_ex_valid = 1'b1; i_mem_addr = o.addr; i_mem_wdata = o.wdata;
        i_ls_info = o.info; i_mem_read = o.rd; i_mem_write = o.wr;
        i_rd_wen = o.rwen; i_rd_addr = o.rda; i_rd_data = o.rdd;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ex_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            i_dmem_gnt = 1'b0;
            i_dmem_rvalid = 1'b0;
            if (o_wb_valid) begin
                r.ok = 1; r.lat = c; r.wen = o_wb_rd_wen;
                r.mis = o_misalign; r.rda = o_wb_rd_addr;
                r.data = o_wb_rd_data; r.bad = o_bad_addr;
                break;
            end
            if (o_dmem_req) begin
                if (!r.req_seen) begin
                    r.req_seen = 1; r.daddr = o_dmem_addr; r.we = o_dmem_we;
                    r.wstrb = o_dmem_wstrb; r.dwdata = o_dmem_wdata;
                end else if (o_dmem_addr !== r.daddr || o_dmem_we !== r.we ||
                             o_dmem_wstrb !== r.wstrb ||
                             o_dmem_wdata !== r.dwdata) begin
                    r.stable = 0;
                end
                if (o_ex_ready) r.stable = 0;
                if (nreq == o.gd) begin
                    i_dmem_gnt = 1'b1;
                    granted = 1'b1;
                    if (o.junk) begin
                        i_dmem_rvalid = 1'b1;
                        i_dmem_rdata = ~o.rdata;
                    end
                end
                nreq++;
            end else if (granted) begin
                if (o_ex_ready) r.stable = 0;
                if (nw == o.rvd) begin
                    i_dmem_rvalid = 1'b1;
                    i_dmem_rdata = o.rdata;
                end
                nw++;
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
        if (r.ok) begin
            @(posedge i_clk);
            @(negedge i_clk);
            r.wb_after = o_wb_valid;
            r.rdy_after = o_ex_ready;
        end
    endtask

    task automatic check_vec(input vec_t v, input res_t r, input string t);
        chk({t, ".done"}, 64'(r.ok), 64'd1);
        chk({t, ".lat"}, 64'(r.lat), 64'(v.e_lat));
        chk({t, ".misalign"}, 64'(r.mis), 64'(v.e_mis));
        chk({t, ".rd_wen"}, 64'(r.wen), 64'(v.e_wen));
        if (v.chk_data) begin
            chk({t, ".rd_data"}, r.data, v.e_data);
            chk({t, ".rd_addr"}, 64'(r.rda), 64'(v.o.rda));
        end
        if (v.e_mis) chk({t, ".bad_addr"}, r.bad, v.o.addr);
        chk({t, ".req"}, 64'(r.req_seen), 64'(v.e_req));
        if (v.e_req) begin
            chk({t, ".dmem_addr"}, r.daddr, v.e_daddr);
            chk({t, ".dmem_we"}, 64'(r.we), 64'(v.e_we));
            chk({t, ".stable"}, 64'(r.stable), 64'd1);
            if (v.e_we) begin
                chk({t, ".wstrb"}, 64'(r.wstrb), 64'(v.e_wstrb));
                chk({t, ".dmem_wdata"}, r.dwdata, v.e_dwdata);
            end
        end
        chk({t, ".wb_pulse"}, 64'(r.wb_after), 64'd0);
        chk({t, ".ready_after"}, 64'(r.rdy_after), 64'd1);
    endtask

    vec_t tbl[17];
    op_t  ro;
    res_t rr;

    initial begin
        tbl[0]  = tv(mk(64'h1003, 0, LB, 1, 0, 1, 5'd9, 0, 64'h8000_0000, 0, 0, 0),
                     3, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 1, 64'h1000, 0, 0, 0);
        tbl[1]  = tv(mk(64'h1003, 0, LBU, 1, 0, 1, 5'd9, 0, 64'h8000_0000, 0, 0, 0),
                     3, 0, 1, 1, 64'h80, 1, 64'h1000, 0, 0, 0);
        tbl[2]  = tv(mk(64'h2006, 64'hABCD, SH, 0, 1, 1, 5'd10, 0, 0, 0, 0, 0),
                     3, 0, 0, 0, 0, 1, 64'h2000, 1, 8'hC0, 64'hABCD_0000_0000_0000);
        tbl[3]  = tv(mk(64'h4008, 0, LD, 1, 0, 1, 5'd11, 0, 64'h1122_3344_5566_7788, 4, 3, 0),
                     10, 0, 1, 1, 64'h1122_3344_5566_7788, 1, 64'h4008, 0, 0, 0);
        tbl[4]  = tv(mk(64'h3002, 0, LW, 1, 0, 1, 5'd12, 0, 0, 0, 0, 0),
                     1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = tv(mk(64'h5006, 0, LH, 1, 0, 1, 5'd13, 0, 64'h8001_0000_0000_0000, 0, 0, 0),
                     3, 0, 1, 1, 64'hFFFF_FFFF_FFFF_8001, 1, 64'h5000, 0, 0, 0);
        tbl[6]  = tv(mk(64'h6004, 0, LWU, 1, 0, 1, 5'd14, 0, 64'hDEAD_BEEF_0000_0000, 1, 0, 0),
                     4, 0, 1, 1, 64'hDEAD_BEEF, 1, 64'h6000, 0, 0, 0);
        tbl[7]  = tv(mk(64'h6004, 0, LW, 1, 0, 1, 5'd15, 0, 64'hDEAD_BEEF_0000_0000, 0, 2, 0),
                     5, 0, 1, 1, 64'hFFFF_FFFF_DEAD_BEEF, 1, 64'h6000, 0, 0, 0);
        tbl[8]  = tv(mk(64'h7004, 64'h1234_5678, SW, 0, 1, 1, 5'd16, 0, 0, 2, 1, 0),
                     6, 0, 0, 0, 0, 1, 64'h7000, 1, 8'hF0, 64'h1234_5678_0000_0000);
        tbl[9]  = tv(mk(64'h7004, 64'h1, SD, 0, 1, 1, 5'd17, 0, 0, 0, 0, 0),
                     1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = tv(mk(64'h1001, 64'h55, LB, 1, 1, 1, 5'd18, 0, 64'h7F00, 0, 0, 0),
                     3, 0, 1, 1, 64'h7F, 1, 64'h1000, 0, 0, 0);
        tbl[11] = tv(mk(64'h8000, 0, 11'h0, 1, 0, 1, 5'd19, 0, 64'hCAFE_BABE_1234_5678, 0, 0, 0),
                     3, 0, 1, 1, 64'hCAFE_BABE_1234_5678, 1, 64'h8000, 0, 0, 0);
        tbl[12] = tv(mk(64'h8004, 64'h9, 11'h0, 0, 1, 1, 5'd20, 0, 0, 0, 0, 0),
                     1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = tv(mk(64'h9002, 0, LHU, 1, 0, 1, 5'd21, 0, 64'hBEEF_0000, 0, 0, 1),
                     3, 0, 1, 1, 64'hBEEF, 1, 64'h9000, 0, 0, 0);
        tbl[14] = tv(mk(64'h3003, 0, LD, 0, 0, 1, 5'd3, 64'h55, 0, 0, 0, 0),
                     1, 0, 1, 1, 64'h55, 0, 0, 0, 0, 0);
        tbl[15] = tv(mk(64'hA007, 64'h1FF, SB, 0, 1, 1, 5'd22, 0, 0, 0, 0, 0),
                     3, 0, 0, 0, 0, 1, 64'hA000, 1, 8'h80, 64'hFF00_0000_0000_0000);
        tbl[16] = tv(mk(64'h0, 0, 11'h0, 0, 0, 0, 5'd4, 64'h77, 0, 0, 0, 0),
                     1, 0, 0, 1, 64'h77, 0, 0, 0, 0, 0);

        i_rst_n = 1'b0; i_ex_valid = 1'b0; i_mem_addr = '0;
        i_mem_wdata = '0; i_ls_info = '0; i_mem_read = 1'b0;
        i_mem_write = 1'b0; i_rd_wen = 1'b0; i_rd_addr = '0;
        i_rd_data = '0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
        i_dmem_rdata = '0;
        #1;
        chk("reset.ready", 64'(o_ex_ready), 64'd1);
        chk("reset.wb_valid", 64'(o_wb_valid), 64'd0);
        chk("reset.dmem_req", 64'(o_dmem_req), 64'd0);
        chk("reset.misalign", 64'(o_misalign), 64'd0);
        chk("reset.bad_addr", o_bad_addr, 64'd0);
        chk("reset.wb_rd_wen", 64'(o_wb_rd_wen), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 17; i++) begin
            do_op(tbl[i].o, rr);
            check_vec(tbl[i], rr, $sformatf("vec%0d", i));
        end

        // Three back-to-back ALU results.
        for (int k = 0; k < 4; k++) begin
            i_ex_valid = (k < 3);
            i_mem_read = 1'b0; i_mem_write = 1'b0; i_rd_wen = 1'b1;
            i_rd_addr = 5'(5 + k); i_rd_data = 64'(k + 1);
            #1;
            chk($sformatf("fwd%0d", k), o_fwd_rd_data, 64'(k + 1));
            @(posedge i_clk);
            @(negedge i_clk);
            chk($sformatf("stream%0d.valid", k), 64'(o_wb_valid), 64'(k < 3));
            chk($sformatf("stream%0d.req", k), 64'(o_dmem_req), 64'd0);
            if (k < 3) begin
                chk($sformatf("stream%0d.rd", k), 64'(o_wb_rd_addr), 64'(5 + k));
                chk($sformatf("stream%0d.data", k), o_wb_rd_data, 64'(k + 1));
            end
        end

        // Reset while waiting for the response, then a stray rvalid.
        i_ex_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_ls_info = LD; i_mem_addr = 64'h100;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ex_valid = 1'b0;
        chk("rst_mid.req", 64'(o_dmem_req), 64'd1);
        i_dmem_gnt = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_dmem_gnt = 1'b0;
        chk("rst_mid.wait_ready", 64'(o_ex_ready), 64'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_mid.req_drop", 64'(o_dmem_req), 64'd0);
        chk("rst_mid.ready", 64'(o_ex_ready), 64'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h1234;
        @(posedge i_clk);
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_mid.no_wb%0d", k), 64'(o_wb_valid), 64'd0);
            chk($sformatf("rst_mid.rdy%0d", k), 64'(o_ex_ready), 64'd1);
            @(negedge i_clk);
        end

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            ro.addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) ro.addr[2:0] = 3'b000;
            ro.wdata = {$urandom, $urandom};
            ro.rdata = {$urandom, $urandom};
            ro.rdd = {$urandom, $urandom};
            ro.rwen = 1'($urandom);
            ro.rda = 5'($urandom);
            ro.gd = int'($urandom_range(0, 3));
            ro.rvd = int'($urandom_range(0, 3));
            ro.junk = 1'($urandom);
            ro.rd = (kind == 1);
            ro.wr = (kind == 2) || (kind == 1 && $urandom_range(0, 7) == 0);
            ro.info = '0;
            if (kind == 1 && $urandom_range(0, 7) != 0)
                ro.info = 11'(1) << (4 + $urandom_range(0, 6));
            else if (kind == 2 && $urandom_range(0, 7) != 0)
                ro.info = 11'(1) << $urandom_range(0, 3);
            do_op(ro, rr);
            check_vec(model(ro), rr, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage sitting directly downstream of the execute stage. It consumes the execute stage's memory address, store data, one-hot load/store info, read/write flags and rd writeback fields.
- Memory ops: issues one data-memory request over a req/gnt + rvalid bus, then aligns and extends load data.
- All results (ALU passthrough, load data, store completion) go to writeback through a registered output.
- Also drives the combinational forwarding value used by the execute stage's bypass.

Parameters:
- AW, 64, address width
- DW, 64, data bus width; fixed at 64, no other value supported

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ex_valid  in  1  execute-stage result valid
- o_ex_ready  out  1  lsu can accept (stall to execute when 0)
- i_mem_addr  in  64  effective address (rs1 + imm)
- i_mem_wdata  in  64  store data, already forwarded
- i_ls_info  in  11  one-hot: [10]lb [9]lh [8]lw [7]ld [6]lbu [5]lhu [4]lwu [3]sb [2]sh [1]sw [0]sd
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_rd_wen  in  1  rd write enable
- i_rd_addr  in  5  rd index
- i_rd_data  in  64  execute-stage ALU/CSR/jal result
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  64  {addr[63:3], 3'b0}
- o_dmem_wdata  out  64  store data shifted to byte lane addr[2:0]
- o_dmem_wstrb  out  8  byte strobes
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  response (load data or write ack)
- i_dmem_rdata  in  64  aligned doubleword
- o_wb_valid  out  1  writeback valid, 1-cycle pulse
- o_wb_rd_wen  out  1
- o_wb_rd_addr  out  5
- o_wb_rd_data  out  64
- o_misalign  out  1  misaligned access exception, pulse with o_wb_valid
- o_bad_addr  out  64  faulting address
- o_fwd_rd_data  out  64  combinational: i_rd_data (forwarding path back to execute)

Behaviour:
- Reset, asynchronous: state = IDLE. All o_wb_*, o_misalign and o_dmem_req go to 0. o_bad_addr and the latched request fields go to 0.
- States:
  - IDLE: o_ex_ready = 1.
  - REQ: o_dmem_req = 1, o_ex_ready = 0.
  - WAIT: o_ex_ready = 0.
- Transfer is accepted when i_ex_valid & o_ex_ready.
- Non-memory op (!read & !write):
  - Next cycle: o_wb_valid = 1, rd fields copied from inputs; state stays IDLE.
  - Back-to-back throughput is 1 per cycle.
- Misalignment:
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0; doubleword requires addr[2:0] = 0.
  - A misaligned op issues no request. Next cycle: o_wb_valid = 1, o_misalign = 1, o_wb_rd_wen = 0, o_bad_addr = i_mem_addr. State stays IDLE.
- Aligned memory op:
  - On accept, latch addr, data, info and rd fields; go to REQ.
  - In REQ, the dmem outputs are held stable until i_dmem_gnt; then go to WAIT.
  - In WAIT, on i_dmem_rvalid: register writeback; o_wb_valid = 1 next cycle; state goes to IDLE.
- Minimum load/store latency: accept at cycle 0, req at cycle 1, gnt at cycle 1, rvalid at cycle 2, o_wb_valid at cycle 3.
- Store writeback: o_wb_rd_wen = 0.
- Load writeback: o_wb_rd_wen = latched rd_wen.
- Load extraction: byte select = rdata >> (addr[2:0]*8).
  - lb/lh/lw: sign-extend 8/16/32 bits.
  - lbu/lhu/lwu: zero-extend.
  - ld: full 64 bits.
- Store lanes: wdata = i_mem_wdata << (addr[2:0]*8).
  - wstrb: sb 8'h01, sh 8'h03, sw 8'h0F, sd 8'hFF, each shifted left by addr[2:0].
- Corner cases:
  - Read and write both set: treated as load.
  - No width bit set within the selected class: treated as doubleword.
- i_dmem_rvalid outside WAIT is ignored, including an rvalid arriving in the same cycle as gnt.
- i_ex_valid is ignored while o_ex_ready = 0; execute holds its inputs.
- Reset asserted mid-transaction: request drops immediately, state goes to IDLE, and a late rvalid is ignored.
- o_wb_valid is a 1-cycle pulse. Writeback never back-pressures.

Test Plan:
- Non-mem stream: 3 consecutive valid ALU results (rd=5,6,7, data 1,2,3) -> o_wb_valid high 3 consecutive cycles, each one cycle later, rd/data matching; o_dmem_req stays 0.
- lb at addr 0x1003, rdata 0x0000_0000_8000_0000, gnt immediate, rvalid next cycle -> o_dmem_addr 0x1000; o_wb_rd_data 0xFFFF_FFFF_FFFF_FF80, wb_valid exactly 3 cycles after accept; lbu with the same data -> 0x80.
- sh at addr 0x2006, wdata 0xABCD -> o_dmem_we = 1, wstrb 8'hC0, wdata 0xABCD_0000_0000_0000; after ack, wb_valid with rd_wen = 0.
- Gnt delayed 4 cycles, rvalid delayed 3 more -> req and addr/wdata/wstrb stable throughout, o_ex_ready low until IDLE, a single wb pulse.
- lw at 0x3002 -> no dmem_req; next cycle o_misalign = 1, o_bad_addr 0x3002, rd_wen = 0.
- Reset asserted in WAIT, then rvalid pulsed after release -> all outputs 0, no o_wb_valid, o_ex_ready = 1.
